// File: rtl/id_stage_param.sv
// Parametrised registered decode stage: register file with write-through bypass, load-use stall FSM, ID/EX register.
// Optional ID_STATS_EN macro adds a saturating stall-cycle counter on Stall_Cycles.
module id_stage_param #(
  parameter int DATA_W          = 32,
  parameter int NUM_REGS        = 32,
  parameter int ADDR_W          = 5,
  parameter int CTRL_W          = 16,
  parameter int MEMREAD_BIT     = 3,
  parameter int LOAD_USE_STALLS = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              IF_Valid,
  input  logic [31:0]       Instruction,
  input  logic [CTRL_W-1:0] Ctrl_In,
  input  logic              SignExt,
  input  logic              Flush,
  input  logic              WB_RegWrite,
  input  logic [ADDR_W-1:0] WB_WriteAddress,
  input  logic [DATA_W-1:0] WB_WriteData,
  output logic              PC_WriteEnable,
  output logic              IFID_WriteEnable,
  output logic              EX_Valid,
  output logic [CTRL_W-1:0] EX_Ctrl,
  output logic [DATA_W-1:0] EX_RD1,
  output logic [DATA_W-1:0] EX_RD2,
  output logic [DATA_W-1:0] EX_Imm,
  output logic [ADDR_W-1:0] EX_Rs,
  output logic [ADDR_W-1:0] EX_Rt,
  output logic [ADDR_W-1:0] EX_Rd,
  output logic [31:0]       Stall_Cycles
);

  typedef enum logic {ST_RUN, ST_STALL} state_t;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  state_t            r_state;
  logic [1:0]        r_cnt;
  logic              r_ex_valid;
  logic [CTRL_W-1:0] r_ex_ctrl;
  logic [DATA_W-1:0] r_ex_rd1, r_ex_rd2, r_ex_imm;
  logic [ADDR_W-1:0] r_ex_rs, r_ex_rt, r_ex_rd;

  logic [ADDR_W-1:0] w_rs, w_rt, w_rd;
  logic [DATA_W-1:0] w_rd1, w_rd2, w_imm;
  logic              w_hz, w_issue_en;
  logic              w_unused;

  assign w_rs     = Instruction[21 +: ADDR_W];
  assign w_rt     = Instruction[16 +: ADDR_W];
  assign w_rd     = Instruction[11 +: ADDR_W];
  assign w_unused = ^Instruction;
  assign w_imm    = SignExt ? DATA_W'($signed(Instruction[15:0])) : DATA_W'(Instruction[15:0]);

  // NOTE: the register file is reset like any other state so a post-reset read is deterministic.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (WB_RegWrite && WB_WriteAddress != '0 && int'(WB_WriteAddress) < NUM_REGS) begin
      r_regs[WB_WriteAddress] <= WB_WriteData;
    end
  end

  // NOTE: outputs get a default first so no path through the block infers a latch.
  always_comb begin
    w_rd1 = '0;
    w_rd2 = '0;
    if (w_rs != '0) begin
      if (WB_RegWrite && WB_WriteAddress == w_rs) w_rd1 = WB_WriteData;
      else if (int'(w_rs) < NUM_REGS)             w_rd1 = r_regs[w_rs];
    end
    if (w_rt != '0) begin
      if (WB_RegWrite && WB_WriteAddress == w_rt) w_rd2 = WB_WriteData;
      else if (int'(w_rt) < NUM_REGS)             w_rd2 = r_regs[w_rt];
    end
  end

  assign w_hz = r_ex_valid && r_ex_ctrl[MEMREAD_BIT] && (r_ex_rt != '0) && IF_Valid &&
                ((r_ex_rt == w_rs) || (r_ex_rt == w_rt));

  // Flush must open the front end even mid-stall so fetch can redirect.
  assign w_issue_en       = Flush || (r_state == ST_RUN && !w_hz);
  assign PC_WriteEnable   = w_issue_en;
  assign IFID_WriteEnable = w_issue_en;

  // NOTE: sequential state uses non-blocking assignments; the bubble is the default load.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_state    <= ST_RUN;
      r_cnt      <= '0;
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_rd1   <= '0;
      r_ex_rd2   <= '0;
      r_ex_imm   <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_rd    <= '0;
    end else begin
      r_ex_valid <= 1'b0;
      r_ex_ctrl  <= '0;
      r_ex_rd1   <= '0;
      r_ex_rd2   <= '0;
      r_ex_imm   <= '0;
      r_ex_rs    <= '0;
      r_ex_rt    <= '0;
      r_ex_rd    <= '0;
      if (Flush) begin
        r_state <= ST_RUN;
        r_cnt   <= '0;
      end else if (r_state == ST_STALL) begin
        // Leave on the cycle the counter reaches zero, giving exactly LOAD_USE_STALLS bubbles.
        if (r_cnt <= 2'd1) begin
          r_state <= ST_RUN;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt - 2'd1;
        end
      end else if (w_hz) begin
        r_cnt   <= 2'(LOAD_USE_STALLS - 1);
        r_state <= (LOAD_USE_STALLS > 1) ? ST_STALL : ST_RUN;
      end else begin
        r_ex_valid <= IF_Valid;
        r_ex_ctrl  <= Ctrl_In;
        r_ex_rd1   <= w_rd1;
        r_ex_rd2   <= w_rd2;
        r_ex_imm   <= w_imm;
        r_ex_rs    <= w_rs;
        r_ex_rt    <= w_rt;
        r_ex_rd    <= w_rd;
      end
    end
  end

  assign EX_Valid = r_ex_valid;
  assign EX_Ctrl  = r_ex_ctrl;
  assign EX_RD1   = r_ex_rd1;
  assign EX_RD2   = r_ex_rd2;
  assign EX_Imm   = r_ex_imm;
  assign EX_Rs    = r_ex_rs;
  assign EX_Rt    = r_ex_rt;
  assign EX_Rd    = r_ex_rd;

`ifdef ID_STATS_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      r_stall_cycles <= '0;
    end else if (!w_issue_en && r_stall_cycles != '1) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign Stall_Cycles = r_stall_cycles;
`else
  assign Stall_Cycles = '0;
`endif

endmodule

// File: tb/tb_id_stage_param.sv
// Directed bench for id_stage_param: dut_a uses one load-use bubble, dut_b three; both share stimulus.
module tb_id_stage_param;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] instr;
  logic [15:0] ctrl_in;
  logic        sign_ext, flush, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        a_pc_we, a_ifid_we, a_ex_valid, b_pc_we, b_ifid_we, b_ex_valid;
  logic [15:0] a_ex_ctrl, b_ex_ctrl;
  logic [31:0] a_ex_rd1, a_ex_rd2, a_ex_imm, b_ex_rd1, b_ex_rd2, b_ex_imm;
  logic [4:0]  a_ex_rs, a_ex_rt, a_ex_rd, b_ex_rs, b_ex_rt, b_ex_rd;
  logic [31:0] a_stall, b_stall;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  id_stage_param dut_a (
    .Clock(clk), .Reset(rst_n), .IF_Valid(if_valid), .Instruction(instr), .Ctrl_In(ctrl_in),
    .SignExt(sign_ext), .Flush(flush), .WB_RegWrite(wb_we), .WB_WriteAddress(wb_addr),
    .WB_WriteData(wb_data), .PC_WriteEnable(a_pc_we), .IFID_WriteEnable(a_ifid_we),
    .EX_Valid(a_ex_valid), .EX_Ctrl(a_ex_ctrl), .EX_RD1(a_ex_rd1), .EX_RD2(a_ex_rd2),
    .EX_Imm(a_ex_imm), .EX_Rs(a_ex_rs), .EX_Rt(a_ex_rt), .EX_Rd(a_ex_rd), .Stall_Cycles(a_stall)
  );

  id_stage_param #(.LOAD_USE_STALLS(3)) dut_b (
    .Clock(clk), .Reset(rst_n), .IF_Valid(if_valid), .Instruction(instr), .Ctrl_In(ctrl_in),
    .SignExt(sign_ext), .Flush(flush), .WB_RegWrite(wb_we), .WB_WriteAddress(wb_addr),
    .WB_WriteData(wb_data), .PC_WriteEnable(b_pc_we), .IFID_WriteEnable(b_ifid_we),
    .EX_Valid(b_ex_valid), .EX_Ctrl(b_ex_ctrl), .EX_RD1(b_ex_rd1), .EX_RD2(b_ex_rd2),
    .EX_Imm(b_ex_imm), .EX_Rs(b_ex_rs), .EX_Rt(b_ex_rt), .EX_Rd(b_ex_rd), .Stall_Cycles(b_stall)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic decode(input logic [4:0] rs, input logic [4:0] rt, input logic [15:0] imm,
                        input logic [15:0] ctrl);
    if_valid = 1'b1;
    instr    = {6'h00, rs, rt, imm};
    ctrl_in  = ctrl;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; if_valid = 1'b0; instr = '0; ctrl_in = '0; sign_ext = 1'b0;
    flush = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0;
    #3;
    total++; if (a_ex_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got %b want 0", a_ex_valid); end
    total++; if (b_ex_ctrl !== 16'h0) begin bad++; $display("FAIL rst_ctrl got %h want 0", b_ex_ctrl); end
    total++; if ({a_pc_we, a_ifid_we, b_pc_we} !== 3'b111) begin bad++; $display("FAIL rst_enables got %b want 111", {a_pc_we, a_ifid_we, b_pc_we}); end
    total++; if (a_stall !== 32'h0) begin bad++; $display("FAIL rst_stats got %h want 0", a_stall); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_regfile;
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h1234; if_valid = 1'b0;
    step();
    wb_we = 1'b0; decode(5'd5, 5'd0, 16'h8001, 16'h0001); sign_ext = 1'b1;
    step();
    total++; if (a_ex_valid !== 1'b1) begin bad++; $display("FAIL rf_valid got %b want 1", a_ex_valid); end
    total++; if (a_ex_rd1 !== 32'h1234) begin bad++; $display("FAIL rf_rd1_r5 got %h want 00001234", a_ex_rd1); end
    total++; if (a_ex_rd2 !== 32'h0) begin bad++; $display("FAIL rf_rd2_r0 got %h want 0", a_ex_rd2); end
    total++; if (a_ex_imm !== 32'hFFFF8001) begin bad++; $display("FAIL rf_imm_sext got %h want ffff8001", a_ex_imm); end
    total++; if ({a_ex_rs, a_ex_rd, a_ex_ctrl} !== {5'd5, 5'h10, 16'h0001}) begin bad++; $display("FAIL rf_fields got %h/%h/%h want 05/10/0001", a_ex_rs, a_ex_rd, a_ex_ctrl); end
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hFFFF; decode(5'd0, 5'd5, 16'h7F00, 16'h0002);
    step();
    total++; if (a_ex_rd1 !== 32'h0) begin bad++; $display("FAIL rf_r0_bypass got %h want 0", a_ex_rd1); end
    total++; if ({a_ex_rd2, a_ex_rt} !== {32'h1234, 5'd5}) begin bad++; $display("FAIL rf_rd2_r5 got %h/%h want 00001234/05", a_ex_rd2, a_ex_rt); end
    total++; if (a_ex_imm !== 32'h00007F00) begin bad++; $display("FAIL rf_imm_pos got %h want 00007f00", a_ex_imm); end
    wb_we = 1'b0; decode(5'd0, 5'd0, 16'h8001, 16'h0004); sign_ext = 1'b0;
    step();
    total++; if (a_ex_rd1 !== 32'h0) begin bad++; $display("FAIL rf_r0_after got %h want 0", a_ex_rd1); end
    total++; if (a_ex_imm !== 32'h00008001) begin bad++; $display("FAIL rf_imm_zext got %h want 00008001", a_ex_imm); end
    if_valid = 1'b0;
    step();
    total++; if (a_ex_valid !== 1'b0) begin bad++; $display("FAIL rf_invalid got %b want 0", a_ex_valid); end
  endtask

  task automatic test_bypass;
    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hA5A5; decode(5'd2, 5'd7, 16'h0, 16'h0001);
    step();
    total++; if (a_ex_rd2 !== 32'hA5A5) begin bad++; $display("FAIL byp_rd2_a got %h want 0000a5a5", a_ex_rd2); end
    total++; if (b_ex_rd2 !== 32'hA5A5) begin bad++; $display("FAIL byp_rd2_b got %h want 0000a5a5", b_ex_rd2); end
    wb_we = 1'b0; decode(5'd7, 5'd7, 16'h0, 16'h0001);
    step();
    total++; if ({a_ex_rd1, a_ex_rd2} !== {32'hA5A5, 32'hA5A5}) begin bad++; $display("FAIL byp_stored got %h/%h want 0000a5a5/0000a5a5", a_ex_rd1, a_ex_rd2); end
  endtask

  task automatic test_load_use;
    decode(5'd1, 5'd3, 16'h0, 16'h0008);
    step();
    decode(5'd3, 5'd4, 16'h0, 16'h0001);
    #1;
    total++; if ({a_pc_we, a_ifid_we, b_pc_we} !== 3'b000) begin bad++; $display("FAIL lu_detect got %b want 000", {a_pc_we, a_ifid_we, b_pc_we}); end
    step();
    total++; if ({a_ex_valid, a_ex_ctrl, a_ex_rs, b_ex_valid} !== {1'b0, 16'h0, 5'd0, 1'b0}) begin bad++; $display("FAIL lu_bubble1 got %b/%h/%h/%b want 0/0000/00/0", a_ex_valid, a_ex_ctrl, a_ex_rs, b_ex_valid); end
    #1;
    total++; if ({a_pc_we, b_pc_we} !== 2'b10) begin bad++; $display("FAIL lu_stall2_en got %b want 10", {a_pc_we, b_pc_we}); end
    step();
    total++; if ({a_ex_valid, a_ex_rs, a_ex_ctrl} !== {1'b1, 5'd3, 16'h0001}) begin bad++; $display("FAIL lu_issue_a got %b/%h/%h want 1/03/0001", a_ex_valid, a_ex_rs, a_ex_ctrl); end
    total++; if (b_ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble2_b got %b want 0", b_ex_valid); end
    #1;
    total++; if (b_pc_we !== 1'b0) begin bad++; $display("FAIL lu_stall3_en got %b want 0", b_pc_we); end
    step();
    total++; if (b_ex_valid !== 1'b0) begin bad++; $display("FAIL lu_bubble3_b got %b want 0", b_ex_valid); end
    #1;
    total++; if ({b_pc_we, b_ifid_we} !== 2'b11) begin bad++; $display("FAIL lu_resume_en got %b want 11", {b_pc_we, b_ifid_we}); end
    step();
    total++; if ({b_ex_valid, b_ex_rs, b_ex_ctrl} !== {1'b1, 5'd3, 16'h0001}) begin bad++; $display("FAIL lu_issue_b got %b/%h/%h want 1/03/0001", b_ex_valid, b_ex_rs, b_ex_ctrl); end
`ifdef ID_STATS_EN
    total++; if ({a_stall, b_stall} !== {32'd1, 32'd3}) begin bad++; $display("FAIL lu_stats got %0d/%0d want 1/3", a_stall, b_stall); end
`else
    total++; if ({a_stall, b_stall} !== 64'd0) begin bad++; $display("FAIL lu_stats got %0d/%0d want 0/0", a_stall, b_stall); end
`endif
    if_valid = 1'b0;
    step();
  endtask

  task automatic test_no_stall;
    decode(5'd1, 5'd0, 16'h0, 16'h0008);
    step();
    decode(5'd0, 5'd0, 16'h0, 16'h0001);
    #1;
    total++; if ({a_pc_we, b_pc_we} !== 2'b11) begin bad++; $display("FAIL ns_load_r0 got %b want 11", {a_pc_we, b_pc_we}); end
    step();
    total++; if (a_ex_valid !== 1'b1) begin bad++; $display("FAIL ns_issue_r0 got %b want 1", a_ex_valid); end
    decode(5'd1, 5'd3, 16'h0, 16'h0008);
    step();
    decode(5'd1, 5'd2, 16'h0, 16'h0001);
    #1;
    total++; if ({a_pc_we, b_pc_we} !== 2'b11) begin bad++; $display("FAIL ns_indep got %b want 11", {a_pc_we, b_pc_we}); end
    step();
    total++; if ({a_ex_valid, a_ex_rs} !== {1'b1, 5'd1}) begin bad++; $display("FAIL ns_issue_indep got %b/%h want 1/01", a_ex_valid, a_ex_rs); end
    decode(5'd1, 5'd3, 16'h0, 16'h0008);
    step();
    decode(5'd3, 5'd3, 16'h0, 16'h0001); if_valid = 1'b0;
    #1;
    total++; if ({a_pc_we, b_pc_we} !== 2'b11) begin bad++; $display("FAIL ns_if_invalid got %b want 11", {a_pc_we, b_pc_we}); end
    step();
  endtask

  task automatic test_flush_stall;
    decode(5'd1, 5'd3, 16'h0, 16'h0008);
    step();
    decode(5'd3, 5'd0, 16'h0, 16'h0001);
    step();
    flush = 1'b1;
    #1;
    total++; if ({b_pc_we, b_ifid_we} !== 2'b11) begin bad++; $display("FAIL fl_enables got %b want 11", {b_pc_we, b_ifid_we}); end
    step();
    total++; if ({b_ex_valid, b_ex_ctrl, a_ex_valid} !== {1'b0, 16'h0, 1'b0}) begin bad++; $display("FAIL fl_bubble got %b/%h/%b want 0/0000/0", b_ex_valid, b_ex_ctrl, a_ex_valid); end
    flush = 1'b0;
    #1;
    total++; if (b_pc_we !== 1'b1) begin bad++; $display("FAIL fl_run got %b want 1", b_pc_we); end
    step();
    total++; if ({b_ex_valid, b_ex_rs} !== {1'b1, 5'd3}) begin bad++; $display("FAIL fl_issue got %b/%h want 1/03", b_ex_valid, b_ex_rs); end
    if_valid = 1'b0;
    step();
  endtask

  task automatic test_async_reset;
    decode(5'd1, 5'd3, 16'h0, 16'h0008);
    step();
    decode(5'd3, 5'd0, 16'h0, 16'h0001);
    step();
    step();
    total++; if ({b_pc_we, a_ex_valid, a_ex_rs} !== {1'b0, 1'b1, 5'd3}) begin bad++; $display("FAIL ar_before got %b/%b/%h want 0/1/03", b_pc_we, a_ex_valid, a_ex_rs); end
    rst_n = 1'b0;
    #1;
    total++; if ({a_ex_valid, a_ex_rs, a_ex_ctrl} !== {1'b0, 5'd0, 16'h0}) begin bad++; $display("FAIL ar_clear got %b/%h/%h want 0/00/0000", a_ex_valid, a_ex_rs, a_ex_ctrl); end
    total++; if ({b_pc_we, b_ifid_we} !== 2'b11) begin bad++; $display("FAIL ar_enables got %b want 11", {b_pc_we, b_ifid_we}); end
    total++; if ({a_stall, b_stall} !== 64'd0) begin bad++; $display("FAIL ar_stats got %0d/%0d want 0/0", a_stall, b_stall); end
    rst_n = 1'b1;
    decode(5'd5, 5'd7, 16'h0, 16'h0001);
    step();
    total++; if ({a_ex_rd1, a_ex_rd2} !== 64'd0) begin bad++; $display("FAIL ar_rf_clear got %h/%h want 0/0", a_ex_rd1, a_ex_rd2); end
  endtask

  initial begin
    test_reset();
    test_regfile();
    test_bypass();
    test_load_use();
    test_no_stall();
    test_flush_stall();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/id_stage_param.md
Name: id_stage_param

Overview:
- Parametrised, registered instruction-decode stage for the five-stage pipeline; successor to the fixed-width decode stage.
- Integrates:
  - register file, with configurable depth/width and same-cycle write-through bypass;
  - load-use hazard unit with a configurable multi-cycle stall FSM;
  - ID/EX pipeline register with valid bit and flush.
- Sits between the IF/ID register and the EX stage. The control bundle comes from the external datapath controller.

Parameters:
- DATA_W, 32, register/data width.
- NUM_REGS, 32, register count (2..32); register 0 hardwired to zero.
- ADDR_W, 5, register address width (clog2 of NUM_REGS; register fields use low ADDR_W bits).
- CTRL_W, 16, width of control bundle carried to EX.
- MEMREAD_BIT, 3, index of the MemRead flag within Ctrl_In.
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..3).

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-low reset
- IF_Valid  in  1  Instruction is a valid instruction
- Instruction  in  32  IF/ID instruction; rs=[25:21], rt=[20:16], rd=[15:11], imm=[15:0]
- Ctrl_In  in  CTRL_W  decoded control for Instruction
- SignExt  in  1  1: sign-extend imm, 0: zero-extend
- Flush  in  1  squash instruction entering EX (taken branch/jump)
- WB_RegWrite  in  1  write-back enable
- WB_WriteAddress  in  ADDR_W  write-back register
- WB_WriteData  in  DATA_W  write-back data
- PC_WriteEnable  out  1  0 freezes PC
- IFID_WriteEnable  out  1  0 freezes IF/ID
- EX_Valid  out  1  ID/EX holds a real instruction
- EX_Ctrl  out  CTRL_W  registered control
- EX_RD1, EX_RD2  out  DATA_W  registered rs/rt data
- EX_Imm  out  DATA_W  registered extended immediate
- EX_Rs, EX_Rt, EX_Rd  out  ADDR_W  registered register fields
- Stall_Cycles  out  32  stall statistic (see Optional Feature)

Behaviour:
Reset (Reset=0, asynchronous):
- All registers, ID/EX contents, EX_Valid and the FSM clear to zero/RUN.
- PC_WriteEnable=1 and IFID_WriteEnable=1 combinationally from reset.

Register file:
- Write on posedge when WB_RegWrite=1 and address≠0. Address 0 always reads 0.
- Reads are combinational with bypass: if WB_RegWrite=1, address≠0 and address matches the read address, read data = WB_WriteData in the same cycle.

Hazard detect (combinational):
- HZ = EX_Valid & EX_Ctrl[MEMREAD_BIT] & EX_Rt≠0 & IF_Valid & (EX_Rt==rs | EX_Rt==rt).

FSM states RUN, STALL; down-counter cnt (2 bits):
- RUN, HZ=0: enables=1; ID/EX loads {IF_Valid, Ctrl_In, RD1, RD2, Imm, rs, rt, rd}.
- RUN, HZ=1: enables=0; bubble loaded (EX_Valid=0, EX_Ctrl=0, other fields don't-care but must be zeroed). cnt←LOAD_USE_STALLS-1. Next state = STALL if LOAD_USE_STALLS>1, else RUN.
- STALL: enables=0; bubble loaded; cnt decrements. At cnt==0, return to RUN next cycle; the instruction then issues normally. No hazard re-detection while in STALL.

Flush:
- Has priority over everything. Next ID/EX = bubble; FSM→RUN, cnt←0.
- Enables=1 during the flush cycle, so IF can redirect.

Latency:
- Decode to EX outputs is 1 cycle. Hazard-stalled instructions take LOAD_USE_STALLS+1 cycles.

Simultaneous events:
- A WB write in a stall cycle completes normally.
- Bypass guarantees that a re-read after a stall sees the write-back value.

Optional Feature:
- ID_STATS_EN defined: Stall_Cycles is a 32-bit counter.
  - Increments each cycle PC_WriteEnable=0; saturates at 0xFFFFFFFF.
  - Cleared by reset only.
- ID_STATS_EN undefined: no counter logic; Stall_Cycles tied to 0.

Test Plan:
- Reset release, WB writes r5=0x1234, then decode "rs=5" → next cycle EX_RD1=0x1234, EX_Valid=1; read of r0 always 0 even after WB write to r0 of 0xFFFF.
- Same-cycle bypass: WB writes r7=0xA5A5 while decoding rt=7 → EX_RD2=0xA5A5 at next edge.
- Load-use, LOAD_USE_STALLS=1: lw r3 then add rs=3 → one cycle with PC_WriteEnable=0 and EX_Valid=0, add issues next cycle; with LOAD_USE_STALLS=3 → exactly 3 bubbles.
- Load to r0, or independent instruction after load → no stall; PC_WriteEnable stays 1.
- Flush during STALL (second of 3 stall cycles) → EX_Valid=0 next cycle, FSM in RUN, enables=1 immediately.
- Async reset asserted mid-stall → outputs clear without a clock edge; with ID_STATS_EN, 3-bubble hazard → Stall_Cycles=3.
